// File: rtl/vga_timing_decoder.sv
// Recovers VGA pixel coordinates from hsync/vsync, measures line/frame lengths and tracks timing lock.
// Optional VGA_DECODER_ERRCNT_EN adds a saturating err_count output.
module vga_timing_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int H_VISIBLE    = 640,
  parameter int V_VISIBLE    = 480,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x_output,
  output logic [9:0] y_output,
  output logic       video_on,
  output logic       locked,
  output logic [9:0] h_measured,
  output logic [9:0] v_measured,
  output logic       frame_start,
  output logic       sync_error
`ifdef VGA_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC_START);
  localparam logic [9:0] H_PRE   = 10'(H_SYNC_START - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC_START);
  localparam logic [9:0] V_PRE   = 10'(V_SYNC_START - 1);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_MISS  = 10'(H_TOTAL + 8);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;

  state_t     state, state_next;
  logic [2:0] match_cnt, match_next, match_inc;
  logic       hs_prev, vs_prev, hs_rise, vs_rise, x_wrap;
  logic [9:0] hcnt, vcnt, hcnt_inc, vcnt_inc, h_current;
  logic       frame_ok, timing_fault, lock_fault, tick_d;

  assign hs_rise   = pixel_tick & hsync_in & ~hs_prev;
  assign vs_rise   = pixel_tick & vsync_in & ~vs_prev;
  assign x_wrap    = pixel_tick & ~hs_rise & (x_output == H_LAST);
  assign hcnt_inc  = (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;
  assign vcnt_inc  = (vcnt == CNT_MAX) ? vcnt : vcnt + 10'd1;
  assign match_inc = match_cnt + 3'd1;

  // A frame qualifies on the measurement that completes at this very edge, not the stale register
  assign h_current = hs_rise ? hcnt_inc : h_measured;
  assign frame_ok  = (h_current == H_TOT) && (vcnt == V_TOT);

  // Faults are judged against the coordinates as they stood before this tick
  assign timing_fault = (hs_rise && (x_output != H_PRE)) ||
                        (vs_rise && (y_output != V_PRE)) ||
                        (pixel_tick && !hs_rise && (hcnt_inc == H_MISS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      match_cnt <= '0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
    end
  end

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    case (state)
      HUNT: begin
        if (vs_rise) begin
          state_next = MEASURE;
          match_next = '0;
        end
      end
      MEASURE: begin
        if (vs_rise) begin
          if (frame_ok) begin
            match_next = match_inc;
            if (match_inc == LOCK_N) state_next = LOCKED;
          end else begin
            match_next = '0;
          end
        end
      end
      LOCKED: begin
        if (timing_fault) begin
          state_next = MEASURE;
          match_next = '0;
        end
      end
      default: begin
        state_next = HUNT;
        match_next = '0;
      end
    endcase
  end

  always_comb begin
    locked     = (state == LOCKED);
    lock_fault = (state == LOCKED) && timing_fault;
  end

  assign video_on = locked && (x_output < H_VIS) && (y_output < V_VIS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev  <= 1'b0;
      vs_prev  <= 1'b0;
      x_output <= '0;
      y_output <= '0;
    end else if (pixel_tick) begin
      hs_prev <= hsync_in;
      vs_prev <= vsync_in;
      if (hs_rise)     x_output <= H_START;
      else if (x_wrap) x_output <= '0;
      else             x_output <= x_output + 10'd1;
      if (vs_rise)     y_output <= V_START;
      else if (x_wrap) y_output <= (y_output == V_LAST) ? 10'd0 : y_output + 10'd1;
    end
  end

  // vcnt counts lines; an hsync edge coinciding with vsync belongs to the new frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt       <= '0;
      vcnt       <= '0;
      h_measured <= '0;
      v_measured <= '0;
    end else if (pixel_tick) begin
      if (hs_rise) begin
        h_measured <= hcnt_inc;
        hcnt       <= '0;
      end else begin
        hcnt <= hcnt_inc;
      end
      if (vs_rise) begin
        v_measured <= vcnt;
        vcnt       <= hs_rise ? 10'd1 : 10'd0;
      end else if (hs_rise) begin
        vcnt <= vcnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d      <= 1'b0;
      frame_start <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      tick_d      <= pixel_tick;
      frame_start <= tick_d && locked && (x_output == 10'd0) && (y_output == 10'd0);
      sync_error  <= lock_fault;
    end
  end

`ifdef VGA_DECODER_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  err_count <= '0;
    else if (lock_fault && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
  end
`endif

endmodule
